// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared constants, parser state encoding and helpers for the
//                UART command parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hEB;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h90;
    localparam int         FRAME_LEN     = 6;

    typedef enum logic [2:0] {
        S_HUNT0 = 3'd0,
        S_HUNT1 = 3'd1,
        S_ADDR  = 3'd2,
        S_DH    = 3'd3,
        S_DL    = 3'd4,
        S_CSUM  = 3'd5
    } parser_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fetch
//  Description : Issues single-cycle RX FIFO read requests and flags the cycle
//                in which the requested byte is present on rx_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fetch (
    input  logic clock,
    input  logic reset,
    input  logic rx_valid,
    output logic rx_rdreq,
    output logic byte_valid
);

    logic pending;

    // A read is only issued when no byte is in flight, so the arrival cycle
    // never carries a new request and reads are spaced at least two apart.
    assign rx_rdreq   = rx_valid && !pending && !reset;
    assign byte_valid = pending;

    // Track the outstanding read; the byte lands the cycle after the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else begin
            pending <= rx_rdreq;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Parses SYNC0 SYNC1 ADDR DATA_H DATA_L CSUM frames from an RX
//                FIFO into configuration register writes, with inter-byte
//                timeout and saturating good/error frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000,
    parameter logic [7:0]  SYNC0       = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1       = SYNC1_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rdreq,
    output logic        cfg_wr,
    output logic [3:0]  cfg_addr,
    output logic [15:0] cfg_data,
    output logic        frame_err,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);

    parser_state_t state;
    logic          byte_valid;
    logic [19:0]   gap;
    logic [3:0]    addr_q;
    logic [7:0]    dh_q;
    logic [7:0]    dl_q;
    logic [7:0]    csum_exp;

    uart_rx_fetch u_fetch (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_rdreq   (rx_rdreq),
        .byte_valid (byte_valid)
    );

    // Expected checksum of the frame collected so far (mod 256).
    always_comb begin
        csum_exp = {4'h0, addr_q} + dh_q + dl_q;
    end

    // Frame parser, gap timer and counters; a byte arrival takes priority
    // over a timeout in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_HUNT0;
            gap       <= 20'd0;
            addr_q    <= 4'h0;
            dh_q      <= 8'h00;
            dl_q      <= 8'h00;
            cfg_wr    <= 1'b0;
            cfg_addr  <= 4'h0;
            cfg_data  <= 16'h0000;
            frame_err <= 1'b0;
            good_cnt  <= 16'h0000;
            err_cnt   <= 16'h0000;
        end else begin
            cfg_wr    <= 1'b0;
            frame_err <= 1'b0;
            if (byte_valid) begin
                gap <= 20'd0;
                case (state)
                    S_HUNT0: begin
                        if (rx_data == SYNC0) begin
                            state <= S_HUNT1;
                        end
                    end
                    S_HUNT1: begin
                        if (rx_data == SYNC1) begin
                            state <= S_ADDR;
                        end else if (rx_data == SYNC0) begin
                            state <= S_HUNT1;
                        end else begin
                            state <= S_HUNT0;
                        end
                    end
                    S_ADDR: begin
                        if (rx_data[7:4] != 4'h0) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc16(err_cnt);
                            state     <= S_HUNT0;
                        end else begin
                            addr_q <= rx_data[3:0];
                            state  <= S_DH;
                        end
                    end
                    S_DH: begin
                        dh_q  <= rx_data;
                        state <= S_DL;
                    end
                    S_DL: begin
                        dl_q  <= rx_data;
                        state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (rx_data == csum_exp) begin
                            cfg_wr   <= 1'b1;
                            cfg_addr <= addr_q;
                            cfg_data <= {dh_q, dl_q};
                            good_cnt <= sat_inc16(good_cnt);
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc16(err_cnt);
                        end
                        state <= S_HUNT0;
                    end
                    default: begin
                        state <= S_HUNT0;
                    end
                endcase
            end else if (state != S_HUNT0) begin
                if (gap >= TIMEOUT_CYC) begin
                    frame_err <= 1'b1;
                    err_cnt   <= sat_inc16(err_cnt);
                    state     <= S_HUNT0;
                    gap       <= 20'd0;
                end else begin
                    gap <= gap + 20'd1;
                end
            end else begin
                gap <= 20'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 20'd100000, the maximum clock cycles allowed between bytes inside a frame.
REQ-002 The block SHALL have parameter SYNC0, default 8'hEB, the first header byte.
REQ-003 The block SHALL have parameter SYNC1, default 8'h90, the second header byte.
REQ-004 clock  in  1  system clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 rx_valid  in  1  RX FIFO not empty.
REQ-007 rx_data  in  8  RX FIFO read data, valid exactly one cycle after rx_rdreq.
REQ-008 rx_rdreq  out  1  RX FIFO read request, one-cycle pulse.
REQ-009 cfg_wr  out  1  configuration write strobe, one-cycle pulse.
REQ-010 cfg_addr  out  4  configuration register index.
REQ-011 cfg_data  out  16  configuration write data.
REQ-012 frame_err  out  1  one-cycle pulse on any rejected frame.
REQ-013 good_cnt  out  16  count of accepted frames, saturating.
REQ-014 err_cnt  out  16  count of rejected frames, saturating.

Function
REQ-015 Fetch: when rx_valid=1 and no read is outstanding, rx_rdreq SHALL pulse for one cycle; the following cycle is the byte-arrival cycle; rx_rdreq SHALL NOT assert in the byte-arrival cycle, so at most one read occurs per 2 cycles.
REQ-016 The frame format SHALL be SYNC0, SYNC1, ADDR, DATA_H, DATA_L, CSUM, where CSUM = (ADDR+DATA_H+DATA_L) mod 256.
REQ-017 Parser states SHALL be HUNT0, HUNT1, ADDR, DH, DL, CSUM; the state advances only on a byte-arrival cycle.
REQ-018 HUNT0: byte==SYNC0 -> HUNT1; otherwise stay in HUNT0, with no error.
REQ-019 HUNT1: byte==SYNC1 -> ADDR; byte==SYNC0 -> stay in HUNT1; otherwise -> HUNT0, with no error.
REQ-020 ADDR: byte[7:4]!=0 -> frame_err and HUNT0; otherwise latch byte[3:0] -> DH.
REQ-021 DH and DL SHALL latch the high and low data bytes respectively and advance.
REQ-022 CSUM: on a match, cfg_wr SHALL pulse in the cycle after arrival with the latched cfg_addr/cfg_data and good_cnt SHALL increment; on a mismatch, frame_err SHALL pulse and no write occurs; both cases return to HUNT0.
REQ-023 cfg_addr and cfg_data SHALL change only together with a cfg_wr pulse and hold their values otherwise.
REQ-024 Timeout: a gap counter SHALL clear on every byte arrival and count in states other than HUNT0; on reaching TIMEOUT_CYC it SHALL pulse frame_err and go to HUNT0.
REQ-025 If a byte arrival and a timeout occur in the same cycle, the byte SHALL win and no timeout occurs.
REQ-026 err_cnt SHALL increment on every frame_err pulse; good_cnt and err_cnt SHALL saturate at 16'hFFFF.
REQ-027 Latency from CSUM byte arrival to cfg_wr SHALL be exactly 1 cycle; back-to-back frames SHALL require no idle gap.

Reset
REQ-028 While reset=1: rx_rdreq=0, cfg_wr=0, frame_err=0, cfg_addr=0, cfg_data=0, good_cnt=0, err_cnt=0, state=HUNT0, gap counter=0, no read outstanding.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, and any byte arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-030 SYNC0/SYNC1 defaults, state encodings and the frame length constant (6) SHALL live in the shared package uart_cmd_pkg.
REQ-031 A single sub-module, uart_rx_fetch (the rdreq/outstanding-read logic of REQ-015), SHALL be instantiated; all other logic is flat.

Verification
REQ-032 Feed EB 90 03 12 34 49 -> one cfg_wr with cfg_addr=3, cfg_data=16'h1234; good_cnt=1.
REQ-033 Feed EB 90 03 12 34 4A -> frame_err pulse, no cfg_wr; err_cnt=1.
REQ-034 Feed 00 EB EB 90 01 00 05 06 -> one cfg_wr with addr=1, data=16'h0005, no frame_err.
REQ-035 Feed EB 90 13 ... -> frame_err on the ADDR byte; the following valid frame is accepted.
REQ-036 With TIMEOUT_CYC=50, feed EB 90 02 then stall 50 cycles -> frame_err; then a full valid frame is accepted.
REQ-037 Assert reset for 1 cycle after EB 90 05 and then feed 12 34 3B -> no cfg_wr, no frame_err, all counters=0.
